l2_burst_adaptor: RTL and testbench

//  Sits between the L2 cache's 256-bit line port and the 64-bit burst physical memory.

---
 rtl/l2_burst_adaptor_pkg.sv | 37 +++
 rtl/l2_write_buffer.sv | 40 ++++
 rtl/l2_burst_adaptor.sv | 127 ++++++++++++
 tb/tb_l2_burst_adaptor.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_burst_adaptor_pkg.sv
// Shared types and sizing for the L2 line port <-> burst memory adaptor.
package l2_burst_adaptor_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned S_OFFSET       = 5;
  localparam int unsigned LINE_W         = 256;
  localparam int unsigned BEAT_W         = 64;
  localparam int unsigned BEATS_PER_LINE = LINE_W / BEAT_W;
  localparam int unsigned BEAT_IDX_W     = $clog2(BEATS_PER_LINE);
  localparam int unsigned TAG_W          = ADDR_W - S_OFFSET;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} adaptor_state_t;

  typedef logic [LINE_W-1:0]     cacheline_t;
  typedef logic [BEAT_W-1:0]     beat_t;
  typedef beat_t [BEATS_PER_LINE-1:0] line_beats_t;
  typedef logic [TAG_W-1:0]      line_tag_t;
  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  // Single write-buffer entry
  typedef struct packed {
    logic       valid;
    line_tag_t  tag;
    cacheline_t data;
  } wb_entry_t;

  // Line tag of a byte address
  function automatic line_tag_t addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:S_OFFSET];
  endfunction

  // Line-aligned byte address of a tag
  function automatic logic [ADDR_W-1:0] tag_addr(input line_tag_t tag);
    return {tag, {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_write_buffer.sv
// Single-entry dirty line buffer: tag compare, load/overwrite, clear, beat select.
module l2_write_buffer
  import l2_burst_adaptor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  line_tag_t  req_tag,
  input  cacheline_t wdata,
  input  beat_idx_t  beat_sel,
  output logic       valid,
  output logic       hit,
  output line_tag_t  tag,
  output cacheline_t data,
  output beat_t      beat_data
);

  wb_entry_t   entry;
  line_beats_t beats;

  // Entry storage; a load on a valid entry simply overwrites it (coalesce)
  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '0;
    end else if (load) begin
      entry <= '{valid: 1'b1, tag: req_tag, data: wdata};
    end else if (clear) begin
      entry.valid <= 1'b0;
    end
  end

  assign valid     = entry.valid;
  assign hit       = entry.valid && (entry.tag == req_tag);
  assign tag       = entry.tag;
  assign data      = entry.data;
  assign beats     = line_beats_t'(entry.data);
  assign beat_data = beats[beat_sel];

endmodule

// File: rtl/l2_burst_adaptor.sv
// L2 256-bit line port to 64-bit 4-beat burst memory, with a one-line write buffer.
module l2_burst_adaptor
  import l2_burst_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_address,
  input  logic              line_read,
  input  logic              line_write,
  input  cacheline_t        line_wdata,
  output cacheline_t        line_rdata,
  output logic              line_resp,
  output logic [ADDR_W-1:0] burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output beat_t             burst_wdata,
  input  beat_t             burst_rdata,
  input  logic              burst_resp
);

  localparam beat_idx_t LAST_BEAT = BEAT_IDX_W'(BEATS_PER_LINE - 1);

  adaptor_state_t state;
  beat_idx_t      beat_cnt;
  line_beats_t    rdata_q;

  logic       wb_valid;
  logic       wb_hit;
  line_tag_t  wb_tag;
  cacheline_t wb_data;
  beat_t      wb_beat;
  logic       wb_load_c;
  logic       wb_clear_c;
  beat_idx_t  beat_sel_c;
  logic       unused_offset_c;

  // Byte offset within a line never affects a line transfer
  assign unused_offset_c = ^line_address[S_OFFSET-1:0];

  // Write capture only when no read is pending and the entry is free or the same line
  assign wb_load_c  = (state == IDLE) && !line_read && line_write && (!wb_valid || wb_hit);
  assign wb_clear_c = (state == DRAIN) && burst_resp && (beat_cnt == LAST_BEAT);
  // Look one beat ahead so burst_wdata is registered in time for the next resp
  assign beat_sel_c = ((state == DRAIN) && burst_resp) ? beat_cnt + BEAT_IDX_W'(1) : beat_cnt;

  l2_write_buffer u_wb (
    .clk       (clk),
    .rst       (rst),
    .load      (wb_load_c),
    .clear     (wb_clear_c),
    .req_tag   (addr_tag(line_address)),
    .wdata     (line_wdata),
    .beat_sel  (beat_sel_c),
    .valid     (wb_valid),
    .hit       (wb_hit),
    .tag       (wb_tag),
    .data      (wb_data),
    .beat_data (wb_beat)
  );

  assign line_rdata = cacheline_t'(rdata_q);

  // Arbitration, burst sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      rdata_q       <= '0;
      line_resp     <= 1'b0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_address <= '0;
      burst_wdata   <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (line_read && wb_hit) begin
            rdata_q   <= line_beats_t'(wb_data);
            line_resp <= 1'b1;
            state     <= RESP;
          end else if (line_read) begin
            burst_read    <= 1'b1;
            burst_address <= tag_addr(addr_tag(line_address));
            state         <= READ;
          end else if (line_write && (!wb_valid || wb_hit)) begin
            line_resp <= 1'b1;
            state     <= RESP;
          end else if (wb_valid) begin
            burst_write   <= 1'b1;
            burst_address <= tag_addr(wb_tag);
            burst_wdata   <= wb_beat;
            state         <= DRAIN;
          end
        end
        READ: begin
          if (burst_resp) begin
            rdata_q[beat_cnt] <= burst_rdata;
            beat_cnt          <= beat_cnt + BEAT_IDX_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        DRAIN: begin
          if (burst_resp) begin
            beat_cnt    <= beat_cnt + BEAT_IDX_W'(1);
            burst_wdata <= wb_beat;
            if (beat_cnt == LAST_BEAT) begin
              burst_write <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// Bench for l2_burst_adaptor: burst memory responder, coherent line reference, directed + random ops.
module tb_l2_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  l2_burst_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .line_address  (line_address),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           start_cyc;
    int           last_cyc;
  } burst_rec_t;

  localparam logic [31:0] LINES [4] = '{32'h0000_0080, 32'h0000_1000, 32'h0000_2020, 32'h0001_0040};

  burst_rec_t   blog[$];
  logic [255:0] mem   [logic [26:0]];
  logic [255:0] ref_m [logic [26:0]];
  int           rsp_delay  = 0;
  int           rsp_beat   = -1;
  int           stray_req  = 0;
  int           stray_done = 0;
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic [26:0] ln(input logic [31:0] a);
    return a[31:5];
  endfunction

  function automatic logic [255:0] mem_rd(input logic [26:0] l);
    return mem.exists(l) ? mem[l] : '0;
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Burst memory: answers a held burst_read/burst_write with 4 consecutive resp beats
  initial begin : mem_model
    logic [255:0] acc, src;
    logic [31:0]  a;
    bit           wr, aborted;
    int           st, last;
    burst_resp  = 1'b0;
    burst_rdata = '0;
    last        = 0;
    mem[ln(32'h1220)] = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    foreach (LINES[i]) mem[ln(LINES[i])] = rnd_line();
    forever begin
      @(negedge clk);
      if (stray_done != stray_req) begin
        for (int k = 0; k < 4; k++) begin
          burst_resp  = 1'b1;
          burst_rdata = {$urandom, $urandom};
          @(negedge clk);
        end
        burst_resp = 1'b0;
        stray_done++;
      end else if (!rst && (burst_read || burst_write)) begin
        wr = burst_write; a = burst_address; st = cyc; aborted = 1'b0;
        acc = '0; src = mem_rd(ln(a));
        repeat (rsp_delay) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          if (rst) begin aborted = 1'b1; break; end
          burst_resp = 1'b1;
          rsp_beat   = k;
          if (wr) acc[k*64 +: 64] = burst_wdata;
          else    burst_rdata = src[k*64 +: 64];
          last = cyc;
          @(negedge clk);
        end
        burst_resp = 1'b0;
        rsp_beat   = -1;
        if (!aborted) begin
          if (wr) mem[ln(a)] = acc;
          blog.push_back('{wr, a, wr ? acc : src, st, last});
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One L2 request held until line_resp; lat counts the request cycle as 1
  task automatic line_op(input bit wr, input logic [31:0] a, input logic [255:0] d,
                         output logic [255:0] rd, output int lat, output int rc);
    int start;
    @(negedge clk);
    line_address = a;
    line_wdata   = d;
    line_read    = !wr;
    line_write   = wr;
    start = cyc; lat = -1; rd = '0; rc = 0;
    assert (!(line_read && line_write)) else begin
      n_err++;
      $error("FAIL protocol: line_read and line_write both high");
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (line_resp) begin
        lat = cyc - start + 1; rd = line_rdata; rc = cyc;
        break;
      end
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    n_vec++;
    assert (lat >= 0) else begin
      n_err++;
      $error("FAIL op_timeout: observed no line_resp expected line_resp addr %0h", a);
    end
    @(posedge clk);
  endtask

  // Wait until memory side is idle for several cycles (all drains finished)
  task automatic quiesce();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 4; i++) begin
      @(negedge clk); #2;
      if (!burst_read && !burst_write && !burst_resp) quiet++;
      else quiet = 0;
    end
    chk_i("quiesce", quiet, 4);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [255:0] rd, d1, d2, da, db;
    logic [31:0]  a;
    int           lat, lat2, rc, nlog, seen, found;

    rst = 1'b1; line_read = 1'b0; line_write = 1'b0;
    line_address = '0; line_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    foreach (mem[k]) ref_m[k] = mem[k];
    chk_i("rst_line_resp",   int'(line_resp),   0);
    chk_i("rst_burst_read",  int'(burst_read),  0);
    chk_i("rst_burst_write", int'(burst_write), 0);
    chk("rst_burst_addr",  256'(burst_address), '0);
    chk("rst_burst_wdata", 256'(burst_wdata),   '0);
    chk("rst_line_rdata",  line_rdata,          '0);
    @(negedge clk); rst = 1'b0;

    // 1: read miss, beat assembly and latency
    rsp_delay = 1;
    nlog = blog.size();
    line_op(1'b0, 32'h0000_1234, '0, rd, lat, rc);
    chk("t1_rdata", rd, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    chk_i("t1_nbursts", blog.size() - nlog, 1);
    if (blog.size() > nlog) begin
      chk_i("t1_kind", int'(blog[nlog].wr), 0);
      chk("t1_addr", 256'(blog[nlog].addr), 256'(32'h0000_1220));
      chk_i("t1_resp_after_beat4", rc - blog[nlog].last_cyc, 1);
    end

    // 2: write capture then wb hit, no read burst
    quiesce();
    d1 = rnd_line();
    nlog = blog.size();
    line_op(1'b1, 32'h0000_0080, d1, rd, lat, rc);
    ref_m[ln(32'h80)] = d1;
    chk_i("t2_wr_lat", lat, 2);
    line_op(1'b0, 32'h0000_0084, '0, rd, lat, rc);
    chk_i("t2_hit_lat", lat, 2);
    chk("t2_hit_data", rd, d1);
    chk_i("t2_no_burst", blog.size() - nlog, 0);
    quiesce();
    chk_i("t2_one_drain", blog.size() - nlog, 1);
    if (blog.size() > nlog) begin
      chk_i("t2_drain_kind", int'(blog[nlog].wr), 1);
      chk("t2_drain_data", blog[nlog].data, d1);
    end

    // 3: read miss bypasses a pending drain
    da = rnd_line();
    nlog = blog.size();
    line_op(1'b1, 32'h0000_2020, da, rd, lat, rc);
    ref_m[ln(32'h2020)] = da;
    line_op(1'b0, 32'h0000_1008, '0, rd, lat, rc);
    chk("t3_read_data", rd, ref_m[ln(32'h1000)]);
    quiesce();
    chk_i("t3_nbursts", blog.size() - nlog, 2);
    if (blog.size() >= nlog + 2) begin
      chk_i("t3_first_is_read", int'(blog[nlog].wr), 0);
      chk("t3_read_addr", 256'(blog[nlog].addr), 256'(32'h0000_1000));
      chk_i("t3_second_is_write", int'(blog[nlog+1].wr), 1);
      chk_i("t3_read_before_write", int'(blog[nlog].last_cyc < blog[nlog+1].start_cyc), 1);
      chk("t3_drain_beats", blog[nlog+1].data, da);
    end

    // 4: second write to another line stalls behind the drain
    rsp_delay = 2;
    da = rnd_line(); db = rnd_line();
    nlog = blog.size();
    line_op(1'b1, 32'h0000_0080, da, rd, lat, rc);
    line_op(1'b1, 32'h0001_0040, db, rd, lat, rc);
    ref_m[ln(32'h80)] = da; ref_m[ln(32'h10040)] = db;
    chk_i("t4_a_drained", blog.size() - nlog, 1);
    if (blog.size() > nlog) begin
      chk("t4_a_data", blog[nlog].data, da);
      chk_i("t4_b_after_a", int'(rc > blog[nlog].last_cyc), 1);
    end
    quiesce();
    chk_i("t4_b_drained", blog.size() - nlog, 2);
    if (blog.size() >= nlog + 2) begin
      chk("t4_b_addr", 256'(blog[nlog+1].addr), 256'(32'h0001_0040));
      chk("t4_b_data", blog[nlog+1].data, db);
    end

    // 5: back-to-back writes to one line coalesce
    rsp_delay = 0;
    d1 = rnd_line(); d2 = rnd_line();
    nlog = blog.size();
    line_op(1'b1, 32'h0000_1000, d1, rd, lat, rc);
    line_op(1'b1, 32'h0000_1010, d2, rd, lat2, rc);
    ref_m[ln(32'h1000)] = d2;
    chk_i("t5_lat1", lat, 2);
    chk_i("t5_lat2", lat2, 2);
    quiesce();
    chk_i("t5_one_drain", blog.size() - nlog, 1);
    if (blog.size() > nlog) chk("t5_drain_data", blog[nlog].data, d2);

    // stray burst_resp while idle must be ignored
    nlog = blog.size();
    seen = 0;
    stray_req++;
    for (int i = 0; i < 20 && stray_done != stray_req; i++) begin
      @(posedge clk); #1;
      seen += int'(line_resp) + int'(burst_read) + int'(burst_write);
    end
    chk_i("stray_done", stray_done, stray_req);
    chk_i("stray_quiet", seen, 0);
    line_op(1'b0, 32'h0000_2020, '0, rd, lat, rc);
    chk("stray_read_data", rd, ref_m[ln(32'h2020)]);

    // 6: reset in the middle of a drain loses the buffered line
    quiesce();
    d1 = rnd_line();
    line_op(1'b1, 32'h0000_0080, d1, rd, lat, rc);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (rsp_beat == 2 && burst_write) begin found = 1; break; end
    end
    chk_i("t6_reach_beat2", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_i("t6_burst_write", int'(burst_write), 0);
    chk_i("t6_line_resp",   int'(line_resp),   0);
    @(negedge clk); #2;
    rst = 1'b0;
    foreach (ref_m[k]) ref_m[k] = mem_rd(k);
    nlog = blog.size();
    line_op(1'b0, 32'h0000_0088, '0, rd, lat, rc);
    chk_i("t6_read_burst", blog.size() - nlog, 1);
    if (blog.size() > nlog) chk_i("t6_read_kind", int'(blog[nlog].wr), 0);
    chk("t6_read_data", rd, ref_m[ln(32'h80)]);

    // random mix over a few lines against the coherent reference
    for (int i = 0; i < 60; i++) begin
      rsp_delay = $urandom_range(0, 3);
      a = LINES[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        d1 = rnd_line();
        line_op(1'b1, a, d1, rd, lat, rc);
        ref_m[ln(a)] = d1;
      end else begin
        line_op(1'b0, a, '0, rd, lat, rc);
        chk("rand_read", rd, ref_m[ln(a)]);
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    quiesce();
    foreach (ref_m[k]) chk("final_mem", mem_rd(k), ref_m[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
